fetch_unit: RTL and testbench

Instruction fetch stage ahead of `decode`. It holds the program counter and issues sequential word fetches to instruction memory over a valid/ready request port. In-order responses are buffered in a small instruction queue, and each instruction is presented to `decode` with its PC. Jump redirects from execute flush the queue and discard in-flight responses.

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, credit-limited imem requests and
// a small instruction queue feeding decode, with redirect flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_encoding,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 2;
    localparam int unsigned DW = CW + 1;
    localparam int unsigned PW =
        (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH = DW'(QUEUE_DEPTH);
    localparam logic [PW-1:0] LAST  = PW'(QUEUE_DEPTH - 1);
    localparam logic [31:0]   NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] enc;
        logic [31:0] pc;
    } entry_t;

    entry_t        slots [QUEUE_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] live;
    logic [CW-1:0] drop;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;

    logic [DW-1:0] inflight;
    logic [31:0]   target;
    logic          credit_ok;
    logic          req_fire;
    logic          resp_live;
    logic          resp_drop;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(
        input logic [PW-1:0] p
    );
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Low two bits of the jump target are forced to zero.
    assign target = redirect_pc & 32'hFFFF_FFFC;

    // A request needs a free queue slot for every kept response.
    assign inflight  = {1'b0, count} + {1'b0, live};
    assign credit_ok = inflight < DEPTH;

    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_drop = imem_resp_valid && (drop != '0);
    assign resp_live = imem_resp_valid && (drop == '0);

    // Redirect wins over any push or pop in its cycle.
    assign push = resp_live && !redirect_valid;
    assign inst_valid = !rst && (count != '0);
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    assign inst_encoding = inst_valid ? slots[head].enc : NOP;
    assign inst_pc       = inst_valid ? slots[head].pc  : '0;

    // Queue payload storage; occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            slots[tail] <= '{enc: imem_resp_data, pc: resp_pc};
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // PCs and in-flight accounting for kept and discarded responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            live     <= '0;
            drop     <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= target;
            resp_pc  <= target;
            live     <= '0;
            drop     <= drop + live - CW'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (resp_live) begin
                resp_pc <= resp_pc + 32'd4;
            end
            live <= live + CW'(req_fire) - CW'(resp_live);
            drop <= drop - CW'(resp_drop);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed stimulus for fetch_unit,
// checked every cycle against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          D   = 2;
    localparam logic [31:0] XK  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_encoding;
    logic [31:0] inst_pc;
    logic        inst_ready;

    fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(D)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_encoding   (inst_encoding),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          keep;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] enc;
        logic [31:0] pc;
    } ins_t;

    req_t        mem_q[$];
    ins_t        iq[$];
    logic [31:0] m_pc;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    bit          k_rst       = 1'b1;
    bit          k_redir     = 1'b0;
    logic [31:0] k_target    = '0;
    int          k_rdy       = 100;
    int          k_irdy      = 100;
    int          k_lat_lo    = 1;
    int          k_lat_hi    = 1;
    int          k_redir_pct = 0;
    int          k_rst_pct   = 0;

    logic        s_rv;
    logic [31:0] s_addr;
    logic        s_iv;
    logic [31:0] s_enc;
    logic [31:0] s_ipc;
    logic        s_resp;
    logic        s_pop;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic bit chance(input int pct);
        return int'($urandom_range(99, 0)) < pct;
    endfunction

    // One clock cycle: drive, compare against model, advance model.
    task automatic step();
        int          nlive;
        bit          rv_e;
        bit          iv_e;
        bit          fire;
        logic [31:0] tgt;
        req_t        r;
        rst = k_rst || chance(k_rst_pct);
        redirect_valid = !rst && (k_redir || chance(k_redir_pct));
        tgt = k_redir ? k_target : $urandom;
        redirect_pc = tgt;
        k_redir = 1'b0;
        imem_req_ready = chance(k_rdy);
        inst_ready = chance(k_irdy);
        imem_resp_valid = 1'b0;
        imem_resp_data = $urandom;
        if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data = mem_q[0].addr ^ XK;
        end
        #1;
        nlive = 0;
        foreach (mem_q[i]) if (mem_q[i].keep) nlive++;
        rv_e = !rst && !redirect_valid && (iq.size() + nlive < D);
        iv_e = !rst && iq.size() > 0;
        check("req_valid", 32'(imem_req_valid), 32'(rv_e));
        if (rv_e) check("req_addr", imem_req_addr, m_pc);
        check("inst_valid", 32'(inst_valid), 32'(iv_e));
        check("inst_enc", inst_encoding,
              iv_e ? iq[0].enc : 32'h0000_0013);
        check("inst_pc", inst_pc, iv_e ? iq[0].pc : 32'h0);
        s_rv = imem_req_valid;
        s_addr = imem_req_addr;
        s_iv = inst_valid;
        s_enc = inst_encoding;
        s_ipc = inst_pc;
        s_resp = imem_resp_valid;
        s_pop = iv_e && inst_ready;
        fire = imem_req_valid && imem_req_ready;
        if (rst) begin
            mem_q.delete();
            iq.delete();
            m_pc = RPC;
        end else begin
            if (imem_resp_valid) begin
                r = mem_q.pop_front();
                if (r.keep && !redirect_valid)
                    check("resp_room", 32'(iq.size() < D), 32'd1);
            end
            if (iv_e && inst_ready && !redirect_valid)
                void'(iq.pop_front());
            if (imem_resp_valid && r.keep && !redirect_valid)
                iq.push_back('{enc: r.addr ^ XK, pc: r.addr});
            if (redirect_valid) begin
                iq.delete();
                foreach (mem_q[i]) mem_q[i].keep = 1'b0;
                m_pc = tgt & 32'hFFFF_FFFC;
            end else if (fire) begin
                mem_q.push_back('{addr: m_pc, keep: 1'b1,
                    due: cyc + int'($urandom_range(k_lat_hi, k_lat_lo))});
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;
        m_pc = RPC;
        @(negedge clk);

        // reset state
        repeat (3) step();
        check("rst_req_valid", 32'(s_rv), 32'd0);
        check("rst_inst_valid", 32'(s_iv), 32'd0);
        check("rst_inst_enc", s_enc, 32'h0000_0013);
        check("rst_inst_pc", s_ipc, 32'h0);
        k_rst = 1'b0;

        // single-cycle memory stream from RESET_PC
        step();
        check("n_req_valid", 32'(s_rv), 32'd1);
        check("n_req_addr", s_addr, 32'h0000_0100);
        step();
        check("n1_req_addr", s_addr, 32'h0000_0104);
        step();
        check("n2_inst_valid", 32'(s_iv), 32'd1);
        check("n2_inst_enc", s_enc, 32'hA5A5_0100);
        check("n2_inst_pc", s_ipc, 32'h0000_0100);
        check("n2_req_valid", 32'(s_rv), 32'd0);
        step();
        check("n3_inst_pc", s_ipc, 32'h0000_0104);
        check("n3_req_addr", s_addr, 32'h0000_0108);
        repeat (6) step();

        // decode stall fills the queue and stops requests
        k_irdy = 0;
        repeat (10) step();
        check("stall_req_valid", 32'(s_rv), 32'd0);
        check("stall_inst_valid", 32'(s_iv), 32'd1);
        k_irdy = 100;
        repeat (10) step();

        // 3-cycle memory, redirect to unaligned target
        k_lat_lo = 3;
        k_lat_hi = 3;
        repeat (6) step();
        k_redir = 1'b1;
        k_target = 32'h0000_2003;
        step();
        check("redir_req_valid", 32'(s_rv), 32'd0);
        step();
        check("redir1_req_valid", 32'(s_rv), 32'd1);
        check("redir1_req_addr", s_addr, 32'h0000_2000);
        check("redir1_inst_valid", 32'(s_iv), 32'd0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (s_iv) begin
                found = 1'b1;
                check("redir_first_pc", s_ipc, 32'h0000_2000);
            end
        end
        if (!found) check("redir_timeout", 32'd0, 32'd1);

        // redirect together with a response and a pop
        k_lat_lo = 1;
        k_lat_hi = 1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc &&
                iq.size() > 0)
                found = 1'b1;
            else
                step();
        end
        if (!found) check("collide_timeout", 32'd0, 32'd1);
        k_redir = 1'b1;
        k_target = 32'h0000_3000;
        step();
        check("collide_resp_pop", {30'd0, s_resp, s_pop}, 32'd3);
        check("collide_req_valid", 32'(s_rv), 32'd0);
        step();
        check("collide_inst_valid", 32'(s_iv), 32'd0);
        repeat (6) step();

        // address wrap at the top of memory
        k_redir = 1'b1;
        k_target = 32'hFFFF_FFFE;
        step();
        step();
        check("wrap_req_addr0", s_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_req_valid", 32'(s_rv), 32'd1);
        check("wrap_req_addr1", s_addr, 32'h0000_0000);
        repeat (4) step();

        // reset with requests outstanding and entries queued
        k_lat_lo = 3;
        k_lat_hi = 3;
        k_irdy = 0;
        repeat (5) step();
        k_rst = 1'b1;
        step();
        check("mid_rst_inst_valid", 32'(s_iv), 32'd0);
        check("mid_rst_inst_enc", s_enc, 32'h0000_0013);
        k_rst = 1'b0;
        k_irdy = 100;
        step();
        check("post_rst_req_valid", 32'(s_rv), 32'd1);
        check("post_rst_req_addr", s_addr, RPC);
        check("post_rst_inst_valid", 32'(s_iv), 32'd0);

        // randomized traffic
        k_rdy = 70;
        k_irdy = 60;
        k_lat_lo = 1;
        k_lat_hi = 4;
        k_redir_pct = 5;
        k_rst_pct = 1;
        repeat (3000) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
